// File: rtl/arbitro_memoria_dados.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_memoria_dados
// Brief   : Two-requester arbiter/sequencer for the shared data memory.
//           Build option ARBITRO_PRIO_FIXA_EN selects fixed priority (req0).
// Revision: 1.0 - initial release
// ============================================================================
module arbitro_memoria_dados #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 32,
  parameter int PROFUNDIDADE = 31
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    esc0,
  input  logic                    esc1,
  input  logic [LARGURA_END-1:0]  end0,
  input  logic [LARGURA_END-1:0]  end1,
  input  logic [LARGURA_DADO-1:0] dado0,
  input  logic [LARGURA_DADO-1:0] dado1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [LARGURA_DADO-1:0] dadoSaida,
  output logic                    erro,
  output logic                    ocupado,
  output logic [LARGURA_END-1:0]  enderecoLeitura,
  output logic [LARGURA_END-1:0]  enderecoEscrita,
  output logic [LARGURA_DADO-1:0] dadoEscrita,
  output logic                    memDadosControle,
  input  logic [LARGURA_DADO-1:0] dadoLeitura
);

  localparam logic [LARGURA_END-1:0] c_PROFUNDIDADE = LARGURA_END'(PROFUNDIDADE);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t                 r_estado;
  estado_t                 w_proxEstado;
  logic                    r_esc;
  logic [LARGURA_END-1:0]  r_end;
  logic [LARGURA_DADO-1:0] r_dado;
  logic                    r_vencedor;
  logic                    r_ack0;
  logic                    r_ack1;
  logic                    r_erro;
  logic [LARGURA_DADO-1:0] r_dadoSaida;
  logic                    w_ultimo;
  logic                    w_vencedor;
  logic                    w_algumReq;
  logic                    w_dentro;
  logic                    w_latch;

  assign w_algumReq = req0 | req1;
  assign w_dentro   = (r_end < c_PROFUNDIDADE);
  assign w_latch    = (r_estado == OCIOSO) && w_algumReq;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_vencedor = 1'b0;
    if (req0 && req1)
      w_vencedor = ~w_ultimo;
    else if (req1)
      w_vencedor = 1'b1;
  end

`ifdef ARBITRO_PRIO_FIXA_EN
  assign w_ultimo = 1'b1;
`else
  logic r_ultimo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_ultimo <= 1'b1;
    else if (w_latch)
      r_ultimo <= w_vencedor;
  end

  assign w_ultimo = r_ultimo;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_estado <= OCIOSO;
    else
      r_estado <= w_proxEstado;
  end

  always_comb begin
    w_proxEstado     = r_estado;
    ocupado          = 1'b0;
    memDadosControle = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_algumReq)
          w_proxEstado = ACESSO;
      end
      ACESSO: begin
        ocupado          = 1'b1;
        memDadosControle = r_esc & w_dentro;
        w_proxEstado     = RESPOSTA;
      end
      RESPOSTA: begin
        ocupado      = 1'b1;
        w_proxEstado = OCIOSO;
      end
      default: w_proxEstado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_esc       <= 1'b0;
      r_end       <= '0;
      r_dado      <= '0;
      r_vencedor  <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_erro      <= 1'b0;
      r_dadoSaida <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_algumReq) begin
            r_vencedor <= w_vencedor;
            r_esc      <= w_vencedor ? esc1  : esc0;
            r_end      <= w_vencedor ? end1  : end0;
            r_dado     <= w_vencedor ? dado1 : dado0;
          end
        end
        ACESSO: begin
          // Writes leave the last read data untouched.
          if (!r_esc)
            r_dadoSaida <= w_dentro ? dadoLeitura : '0;
          r_erro <= ~w_dentro;
          r_ack0 <= ~r_vencedor;
          r_ack1 <= r_vencedor;
        end
        RESPOSTA: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_erro <= 1'b0;
        end
        default: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_erro <= 1'b0;
        end
      endcase
    end
  end

  assign ack0            = r_ack0;
  assign ack1            = r_ack1;
  assign erro            = r_erro;
  assign dadoSaida       = r_dadoSaida;
  assign enderecoLeitura = r_end;
  assign enderecoEscrita = r_end;
  assign dadoEscrita     = r_dado;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria_dados.sv
`default_nettype none
// ============================================================================
// Module  : tb_arbitro_memoria_dados
// Brief   : Directed bench for arbitro_memoria_dados with a 31-word memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arbitro_memoria_dados;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, esc0 = 1'b0, esc1 = 1'b0;
  logic [31:0] end0 = '0, end1 = '0, dado0 = '0, dado1 = '0;
  logic        ack0, ack1, erro, ocupado, memDadosControle;
  logic [31:0] dadoSaida, enderecoLeitura, enderecoEscrita, dadoEscrita;
  logic [31:0] dadoLeitura;

  logic [31:0] mem [0:30];
  int          checks = 0;
  int          failures = 0;
  int          sobreposicao = 0;
  int          escritaIlegal = 0;
  logic        esperado0;
  logic [31:0] ultimoLido;

  arbitro_memoria_dados #(
    .LARGURA_DADO(32),
    .LARGURA_END (32),
    .PROFUNDIDADE(31)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req0            (req0),
    .req1            (req1),
    .esc0            (esc0),
    .esc1            (esc1),
    .end0            (end0),
    .end1            (end1),
    .dado0           (dado0),
    .dado1           (dado1),
    .ack0            (ack0),
    .ack1            (ack1),
    .dadoSaida       (dadoSaida),
    .erro            (erro),
    .ocupado         (ocupado),
    .enderecoLeitura (enderecoLeitura),
    .enderecoEscrita (enderecoEscrita),
    .dadoEscrita     (dadoEscrita),
    .memDadosControle(memDadosControle),
    .dadoLeitura     (dadoLeitura)
  );

  always #5 clock = ~clock;

  // Memory model: combinational read, synchronous write.
  always_comb begin
    dadoLeitura = '0;
    if (enderecoLeitura < 32'd31)
      dadoLeitura = mem[enderecoLeitura[4:0]];
  end

  always @(posedge clock) begin
    if (memDadosControle) begin
      if (enderecoEscrita < 32'd31)
        mem[enderecoEscrita[4:0]] <= dadoEscrita;
      else
        escritaIlegal <= escritaIlegal + 1;
    end
  end

  always @(negedge clock)
    if (ack0 && ack1) sobreposicao <= sobreposicao + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 31; i++) mem[i] = 32'hA000_0000 + i;

    // Reset state
    tick();
    tick();
    chk("rst_ack", {30'd0, ack0, ack1}, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_dadoSaida", dadoSaida, 32'd0);
    chk("rst_endL", enderecoLeitura, 32'd0);
    chk("rst_endE", enderecoEscrita, 32'd0);
    chk("rst_dadoE", dadoEscrita, 32'd0);
    chk("rst_we", {31'd0, memDadosControle}, 32'd0);
    reset = 1'b0;
    tick();

    // Write 0xDEADBEEF to address 5, then read it back
    req0 = 1'b1; esc0 = 1'b1; end0 = 32'd5; dado0 = 32'hDEADBEEF;
    tick();
    chk("wr_we_acesso", {31'd0, memDadosControle}, 32'd1);
    chk("wr_ocupado", {31'd0, ocupado}, 32'd1);
    chk("wr_ack_early", {31'd0, ack0}, 32'd0);
    chk("wr_endE", enderecoEscrita, 32'd5);
    chk("wr_dadoE", dadoEscrita, 32'hDEADBEEF);
    tick();
    chk("wr_ack0", {30'd0, ack0, ack1}, 32'd2);
    chk("wr_erro", {31'd0, erro}, 32'd0);
    chk("wr_we_resp", {31'd0, memDadosControle}, 32'd0);
    chk("wr_mem5", mem[5], 32'hDEADBEEF);
    req0 = 1'b0;
    tick();
    chk("wr_idle", {29'd0, ocupado, ack0, ack1}, 32'd0);
    req0 = 1'b1; esc0 = 1'b0; end0 = 32'd5;
    tick();
    chk("rd_we", {31'd0, memDadosControle}, 32'd0);
    chk("rd_endL", enderecoLeitura, 32'd5);
    tick();
    chk("rd_ack0", {30'd0, ack0, ack1}, 32'd2);
    chk("rd_dado", dadoSaida, 32'hDEADBEEF);
    chk("rd_erro", {31'd0, erro}, 32'd0);
    req0 = 1'b0;
    tick();

    // Tie right after reset: requester 0 first, requester 1 three cycles later
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; esc0 = 1'b0; end0 = 32'd1;
    req1 = 1'b1; esc1 = 1'b0; end1 = 32'd2;
    tick();
    tick();
    chk("tie_first", {30'd0, ack0, ack1}, 32'd2);
    chk("tie_first_dado", dadoSaida, 32'hA000_0001);
    req0 = 1'b0;
    tick();
    chk("tie_gap", {30'd0, ack0, ack1}, 32'd0);
    tick();
    tick();
    chk("tie_second", {30'd0, ack0, ack1}, 32'd1);
    chk("tie_second_dado", dadoSaida, 32'hA000_0002);
    req1 = 1'b0;
    tick();

    // Both requesters hold req for 6 services
    req0 = 1'b1; end0 = 32'd7;
    req1 = 1'b1; end1 = 32'd8;
    for (int k = 0; k < 6; k++) begin
`ifdef ARBITRO_PRIO_FIXA_EN
      esperado0 = 1'b1;
`else
      esperado0 = (k % 2 == 0);
`endif
      tick();
      tick();
      chk($sformatf("alt_grant%0d", k), {30'd0, ack0, ack1}, {30'd0, esperado0, ~esperado0});
      chk($sformatf("alt_dado%0d", k), dadoSaida, esperado0 ? 32'hA000_0007 : 32'hA000_0008);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
`ifdef ARBITRO_PRIO_FIXA_EN
    ultimoLido = 32'hA000_0007;
`else
    ultimoLido = 32'hA000_0008;
`endif
    tick();

    // Out-of-range write and read at address 31
    req1 = 1'b1; esc1 = 1'b1; end1 = 32'd31; dado1 = 32'h5555_5555;
    tick();
    chk("oor_wr_we", {31'd0, memDadosControle}, 32'd0);
    chk("oor_wr_ocupado", {31'd0, ocupado}, 32'd1);
    tick();
    chk("oor_wr_ack1", {30'd0, ack0, ack1}, 32'd1);
    chk("oor_wr_erro", {31'd0, erro}, 32'd1);
    chk("oor_wr_keep", dadoSaida, ultimoLido);
    req1 = 1'b0;
    tick();
    chk("oor_wr_clear", {30'd0, erro, ack1}, 32'd0);
    req1 = 1'b1; esc1 = 1'b0; end1 = 32'd31;
    tick();
    tick();
    chk("oor_rd_ack1", {30'd0, ack0, ack1}, 32'd1);
    chk("oor_rd_erro", {31'd0, erro}, 32'd1);
    chk("oor_rd_dado", dadoSaida, 32'd0);
    req1 = 1'b0;
    tick();

    // Reset during the access cycle of a write
    req0 = 1'b1; esc0 = 1'b1; end0 = 32'd3; dado0 = 32'h12345678;
    tick();
    chk("rstmid_we_before", {31'd0, memDadosControle}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_we_async", {31'd0, memDadosControle}, 32'd0);
    chk("rstmid_ocupado", {31'd0, ocupado}, 32'd0);
    req0 = 1'b0;
    tick();
    chk("rstmid_noack", {29'd0, erro, ack0, ack1}, 32'd0);
    chk("rstmid_mem3", mem[3], 32'hA000_0003);
    reset = 1'b0;
    tick();
    req0 = 1'b1; esc0 = 1'b0; end0 = 32'd3;
    tick();
    tick();
    chk("rstmid_rd_ack0", {30'd0, ack0, ack1}, 32'd2);
    chk("rstmid_rd_dado", dadoSaida, 32'hA000_0003);
    req0 = 1'b0;
    tick();

    // Idle for 10 cycles
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("idle%0d", k), {28'd0, ocupado, memDadosControle, ack0, ack1}, 32'd0);
    end

    chk("ack_overlap", sobreposicao, 32'd0);
    chk("illegal_write", escritaIlegal, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
